uart_tx_line_arbiter: RTL and testbench

Line-granular arbiter that shares one testbench/SoC UART transmitter among `NUM_REQ` byte-stream requesters. A requester, once granted, owns the transmitter until it sends a line-feed (8'h0a), hits the line-length limit, or goes idle past a timeout. Lines from different sources therefore never interleave in the downstream line-logging UART receiver. Sits between the requester byte sources and the `uart_tx` instance driving `uart_txd`.

---
 rtl/uart_tx_line_arbiter.sv | 132 +++++++++++++
 tb/tb_uart_tx_line_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_line_arbiter.sv
// Line-granular arbiter sharing one uart_tx among NUM_REQ byte requesters; an owner keeps the line until LF, MAX_LINE or idle timeout.
// Latency: grant one cycle after req_valid in IDLE, first launch one cycle later; launch-to-launch >= 3 cycles plus uart busy time.
// Backpressure: owner's byte is held until its req_ready pulse; tx_busy stalls launches and freezes the idle timer.
module uart_tx_line_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int PAYLOAD_BITS = 8,
  parameter int MAX_LINE     = 132,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0]   req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              tx_en,
  output logic [PAYLOAD_BITS-1:0]           tx_data,
  input  logic                              tx_busy,
  output logic                              grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]        grant_id,
  output logic                              line_forced
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BCW = $clog2(MAX_LINE + 1);
  localparam int ICW = $clog2(IDLE_TIMEOUT);
  localparam logic [PAYLOAD_BITS-1:0] LF_BYTE = PAYLOAD_BITS'(10);

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_LAUNCH, S_DRAIN} state_t;

  state_t                  state;
  logic [IDW-1:0]          rr_ptr;
  logic [BCW-1:0]          byte_cnt;
  logic [ICW-1:0]          idle_cnt;
  logic                    last_lf;

  logic                    win_found;
  logic [IDW-1:0]          win_id;
  logic [IDW-1:0]          next_rr;
  logic [PAYLOAD_BITS-1:0] owner_dat;
  int                      rr_idx;

  // Round-robin search upward from rr_ptr with wrap; first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    rr_idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!win_found && req_valid[rr_idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(rr_idx);
      end
    end
  end

  always_comb begin
    next_rr   = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
    owner_dat = req_data[int'(grant_id)*PAYLOAD_BITS +: PAYLOAD_BITS];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      byte_cnt    <= '0;
      idle_cnt    <= '0;
      last_lf     <= 1'b0;
      req_ready   <= '0;
      tx_en       <= 1'b0;
      tx_data     <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      line_forced <= 1'b0;
    end else begin
      req_ready   <= '0;
      tx_en       <= 1'b0;
      line_forced <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            grant_id    <= win_id;
            grant_valid <= 1'b1;
            byte_cnt    <= '0;
            idle_cnt    <= '0;
            state       <= S_OWN;
          end
        end
        S_OWN: begin
          if (req_valid[grant_id] && !tx_busy) begin
            req_ready <= NUM_REQ'(1) << grant_id;
            tx_en     <= 1'b1;
            tx_data   <= owner_dat;
            last_lf   <= (owner_dat == LF_BYTE);
            if (byte_cnt != BCW'(MAX_LINE))
              byte_cnt <= byte_cnt + BCW'(1);
            idle_cnt  <= '0;
            state     <= S_LAUNCH;
          end else if (!req_valid[grant_id] && !tx_busy) begin
            // Stalled owner: the timer only runs while the transmitter is free.
            if (idle_cnt == ICW'(IDLE_TIMEOUT - 1)) begin
              grant_valid <= 1'b0;
              rr_ptr      <= next_rr;
              line_forced <= 1'b1;
              state       <= S_IDLE;
            end else begin
              idle_cnt <= idle_cnt + ICW'(1);
            end
          end
        end
        S_LAUNCH: state <= S_DRAIN;
        S_DRAIN: begin
          if (!tx_busy) begin
            if (last_lf) begin
              grant_valid <= 1'b0;
              rr_ptr      <= next_rr;
              state       <= S_IDLE;
            end else if (byte_cnt == BCW'(MAX_LINE)) begin
              grant_valid <= 1'b0;
              rr_ptr      <= next_rr;
              line_forced <= 1'b1;
              state       <= S_IDLE;
            end else begin
              state <= S_OWN;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_line_arbiter.sv
// Bench for uart_tx_line_arbiter: per-requester byte sources, a simple busy-holding uart model,
// and a line-level scheduling model that predicts byte order, grant order and forced releases.
module tb_uart_tx_line_arbiter;
  localparam int NR = 4;
  localparam int PB = 8;
  localparam int ML = 132;
  localparam int IT = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic [NR-1:0] req_valid;
  logic [NR*PB-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          tx_en;
  logic [PB-1:0] tx_data;
  logic          tx_busy;
  logic          grant_valid;
  logic [1:0]    grant_id;
  logic          line_forced;

  uart_tx_line_arbiter #(.NUM_REQ(NR), .PAYLOAD_BITS(PB), .MAX_LINE(ML), .IDLE_TIMEOUT(IT)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_en(tx_en), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_valid(grant_valid), .grant_id(grant_id), .line_forced(line_forced)
  );

  initial forever #5 clk = ~clk;

  // Byte sources
  logic [7:0] src_mem [NR][256];
  int src_len [NR];
  int src_pos [NR];

  // Predicted and observed traffic
  int exp_id [1024];  logic [7:0] exp_dat [1024];  int exp_n;
  int exp_grant [64]; int exp_forced [64];         int exp_ng;
  int act_id [1024];  logic [7:0] act_dat [1024];  int act_txcyc [1024]; int act_n;
  int act_grant [64]; int act_gbytes [64];         int act_ng;
  int act_forced [64]; int act_nrel;
  int first_fcyc, lf_count, proto_err, min_sp, max_sp;
  int model_rr, busy_cnt;
  int n_checks, n_fail;

  task automatic clear_src();
    for (int i = 0; i < NR; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end
  endtask

  // n bytes of random non-LF data, last byte LF when lf_end
  task automatic load_line(input int i, input int n, input bit lf_end);
    for (int j = 0; j < n; j++) begin
      logic [7:0] b;
      b = 8'($urandom_range(255, 0));
      if (b == 8'h0a) b = 8'h0b;
      src_mem[i][src_len[i] + j] = b;
    end
    if (lf_end) src_mem[i][src_len[i] + n - 1] = 8'h0a;
    src_len[i] = src_len[i] + n;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      if (src_pos[i] < src_len[i]) begin
        req_valid[i]         = 1'b1;
        req_data[i*PB +: PB] = src_mem[i][src_pos[i]];
      end else begin
        req_valid[i]         = 1'b0;
        req_data[i*PB +: PB] = '0;
      end
    end
  endtask

  // Line-level schedule: winner is the first pending source from model_rr; a line ends
  // on LF, after ML bytes, or when the source runs dry (which ends in a timeout).
  task automatic build_model();
    int pos [NR];
    int w, cnt;
    logic [7:0] lastb;
    exp_n = 0; exp_ng = 0;
    for (int i = 0; i < NR; i++) pos[i] = src_pos[i];
    while (1) begin
      w = -1;
      for (int k = 0; k < NR; k++) begin
        int idx;
        idx = (model_rr + k) % NR;
        if (w < 0 && pos[idx] < src_len[idx]) w = idx;
      end
      if (w < 0) break;
      exp_grant[exp_ng] = w;
      cnt = 0; lastb = 8'h00;
      while (pos[w] < src_len[w] && cnt < ML) begin
        lastb = src_mem[w][pos[w]];
        pos[w]++;
        exp_id[exp_n] = w; exp_dat[exp_n] = lastb; exp_n++;
        cnt++;
        if (lastb == 8'h0a) break;
      end
      exp_forced[exp_ng] = (lastb != 8'h0a) ? 1 : 0;
      exp_ng++;
      model_rr = (w + 1) % NR;
    end
  endtask

  task automatic run_traffic(input int busy_max, input int budget);
    int cyc, pending, sp, blen;
    bit done, prev_gv;
    build_model();
    act_n = 0; act_ng = 0; act_nrel = 0; first_fcyc = -1; lf_count = 0; proto_err = 0;
    min_sp = 1000000; max_sp = 0;
    prev_gv = grant_valid;
    cyc = 0; done = 0;
    begin
      int last_tx;
      last_tx = -1;
      drive_reqs();
      while (!done && cyc < budget) begin
        @(posedge clk); #1; cyc++;
        if (tx_en) begin
          if (act_n < 1024) begin
            act_id[act_n] = int'(grant_id); act_dat[act_n] = tx_data; act_txcyc[act_n] = cyc;
          end
          act_n++;
          if (!grant_valid || req_ready != (4'b0001 << grant_id)) proto_err++;
          if (act_ng > 0) act_gbytes[act_ng-1]++;
          if (last_tx >= 0) begin
            sp = cyc - last_tx;
            if (sp < min_sp) min_sp = sp;
            if (sp > max_sp) max_sp = sp;
          end
          last_tx = cyc;
        end else if (req_ready != '0) proto_err++;
        if (line_forced) begin
          lf_count++;
          if (first_fcyc < 0) first_fcyc = cyc;
        end
        if (grant_valid && !prev_gv && act_ng < 64) begin
          act_grant[act_ng] = int'(grant_id); act_gbytes[act_ng] = 0; act_ng++;
        end
        if (!grant_valid && prev_gv) begin
          if (act_nrel < 64) act_forced[act_nrel] = line_forced ? 1 : 0;
          act_nrel++;
        end else if (line_forced) proto_err++;
        prev_gv = grant_valid;
        // uart model: busy for a random number of cycles after each launch
        if (tx_en) begin
          blen = (busy_max == 0) ? 0 : int'($urandom_range(busy_max, 0));
          busy_cnt = blen;
        end
        if (busy_cnt > 0) begin tx_busy = 1'b1; busy_cnt--; end
        else tx_busy = 1'b0;
        for (int i = 0; i < NR; i++) if (req_ready[i]) src_pos[i]++;
        drive_reqs();
        pending = 0;
        for (int i = 0; i < NR; i++) if (src_pos[i] < src_len[i]) pending++;
        done = (pending == 0) && !grant_valid && !tx_busy;
      end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL traffic_timeout: still busy after %0d cycles, required completion", budget);
    end
  endtask

  function automatic int log_diff();
    int n;
    n = (act_n < exp_n) ? act_n : exp_n;
    for (int k = 0; k < n; k++)
      if (act_id[k] != exp_id[k] || act_dat[k] !== exp_dat[k]) return k;
    return (act_n == exp_n) ? -1 : n;
  endfunction

  function automatic int grant_diff();
    int n;
    n = (act_ng < exp_ng) ? act_ng : exp_ng;
    for (int k = 0; k < n; k++) if (act_grant[k] != exp_grant[k]) return k;
    return (act_ng == exp_ng) ? -1 : n;
  endfunction

  function automatic int rel_diff();
    int n;
    n = (act_nrel < exp_ng) ? act_nrel : exp_ng;
    for (int k = 0; k < n; k++) if (act_forced[k] != exp_forced[k]) return k;
    return (act_nrel == exp_ng) ? -1 : n;
  endfunction

  task automatic do_reset();
    resetn = 1'b0; req_valid = '0; req_data = '0; tx_busy = 1'b0; busy_cnt = 0;
    clear_src();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    model_rr = 0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; req_valid = '0; req_data = '0; tx_busy = 1'b0;
    #2;
    n_checks++;
    if ({req_ready, tx_en, tx_data, grant_valid, grant_id, line_forced} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0", {req_ready, tx_en, tx_data, grant_valid, grant_id, line_forced});
    end
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({grant_valid, tx_en, req_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: got %b, required 0 with no requests", {grant_valid, tx_en, req_ready});
    end
    model_rr = 0;
  endtask

  task automatic test_single();
    do_reset();
    src_mem[1][0] = 8'h4f; src_mem[1][1] = 8'h4b; src_mem[1][2] = 8'h0a; src_len[1] = 3;
    run_traffic(0, 200);
    n_checks++; if (act_n !== 3) begin n_fail++; $display("FAIL single_count: got %0d launches, required 3", act_n); end
    n_checks++; if (log_diff() !== -1) begin n_fail++; $display("FAIL single_bytes: first diff at %0d, required none", log_diff()); end
    n_checks++; if (act_txcyc[0] !== 2) begin n_fail++; $display("FAIL single_latency: first launch at cycle %0d, required 2", act_txcyc[0]); end
    n_checks++; if (act_ng !== 1 || act_grant[0] !== 1) begin n_fail++; $display("FAIL single_grant: %0d grants, first id %0d, required 1 grant to id 1", act_ng, act_grant[0]); end
    n_checks++; if (lf_count !== 0) begin n_fail++; $display("FAIL single_forced: %0d line_forced pulses, required 0", lf_count); end
    n_checks++; if (min_sp !== 3 || max_sp !== 3) begin n_fail++; $display("FAIL single_spacing: min %0d max %0d, required 3 and 3", min_sp, max_sp); end
    n_checks++; if (proto_err !== 0) begin n_fail++; $display("FAIL single_protocol: %0d handshake errors, required 0", proto_err); end
  endtask

  task automatic test_contention();
    do_reset();
    load_line(0, 5, 1);
    load_line(2, 5, 1);
    run_traffic(3, 500);
    n_checks++; if (log_diff() !== -1) begin n_fail++; $display("FAIL contention_bytes: first diff at %0d, required none", log_diff()); end
    n_checks++; if (act_ng !== 2 || act_grant[0] !== 0 || act_grant[1] !== 2) begin n_fail++; $display("FAIL contention_order: %0d grants %0d,%0d required 0,2", act_ng, act_grant[0], act_grant[1]); end
    n_checks++; if (proto_err !== 0) begin n_fail++; $display("FAIL contention_protocol: %0d handshake errors, required 0", proto_err); end
    // pointer left at 3: requesters 0,1,3 together must start with 3
    clear_src();
    load_line(0, 1, 1); load_line(1, 1, 1); load_line(3, 1, 1);
    run_traffic(1, 300);
    n_checks++; if (act_grant[0] !== 3) begin n_fail++; $display("FAIL contention_rr_ptr: first grant %0d, required 3", act_grant[0]); end
    n_checks++; if (grant_diff() !== -1) begin n_fail++; $display("FAIL contention_rr_order: first diff at %0d, required none", grant_diff()); end
  endtask

  task automatic test_fairness();
    int bad;
    do_reset();
    for (int i = 0; i < NR; i++) load_line(i, 2, 0);
    for (int i = 0; i < NR; i++) begin src_mem[i][0] = 8'h0a; src_mem[i][1] = 8'h0a; end
    run_traffic(2, 800);
    bad = 0;
    for (int k = 0; k < 8; k++) if (act_grant[k] != k % NR) bad++;
    n_checks++; if (act_ng !== 8 || bad !== 0) begin n_fail++; $display("FAIL fairness_order: %0d grants, %0d out of order, required 8 grants 0,1,2,3,0,1,2,3", act_ng, bad); end
    n_checks++; if (log_diff() !== -1) begin n_fail++; $display("FAIL fairness_bytes: first diff at %0d, required none", log_diff()); end
  endtask

  task automatic test_line_limit();
    clear_src();
    load_line(3, 140, 0);
    run_traffic(2, 4000);
    n_checks++; if (act_n !== 140) begin n_fail++; $display("FAIL limit_count: got %0d launches, required 140", act_n); end
    n_checks++; if (log_diff() !== -1) begin n_fail++; $display("FAIL limit_bytes: first diff at %0d, required none", log_diff()); end
    n_checks++; if (act_ng !== 2 || act_grant[0] !== 3 || act_grant[1] !== 3 || act_gbytes[0] !== 132) begin n_fail++; $display("FAIL limit_grants: %0d grants, first has %0d bytes, required 2 grants to id 3 with 132 first", act_ng, act_gbytes[0]); end
    n_checks++; if (rel_diff() !== -1 || act_forced[0] !== 1) begin n_fail++; $display("FAIL limit_forced: release pattern diff at %0d, first forced %0d, required forced release", rel_diff(), act_forced[0]); end
  endtask

  task automatic test_lf_at_limit();
    clear_src();
    load_line(2, 132, 1);
    run_traffic(1, 3000);
    n_checks++; if (act_ng !== 1 || act_gbytes[0] !== 132) begin n_fail++; $display("FAIL lf_limit_grant: %0d grants, %0d bytes, required 1 grant of 132", act_ng, act_gbytes[0]); end
    n_checks++; if (lf_count !== 0) begin n_fail++; $display("FAIL lf_limit_forced: %0d line_forced pulses, required 0", lf_count); end
    n_checks++; if (log_diff() !== -1) begin n_fail++; $display("FAIL lf_limit_bytes: first diff at %0d, required none", log_diff()); end
  endtask

  task automatic test_idle_timeout();
    do_reset();
    load_line(0, 2, 0);
    load_line(1, 2, 1);
    run_traffic(0, 500);
    n_checks++; if (grant_diff() !== -1 || act_grant[1] !== 1) begin n_fail++; $display("FAIL idle_order: diff at %0d, second grant %0d, required 0 then 1", grant_diff(), act_grant[1]); end
    n_checks++; if (rel_diff() !== -1 || act_forced[0] !== 1) begin n_fail++; $display("FAIL idle_forced: diff at %0d, first forced %0d, required 1", rel_diff(), act_forced[0]); end
    // LAUNCH and DRAIN, then IT stalled cycles in OWN
    n_checks++; if (first_fcyc - act_txcyc[1] !== IT + 2) begin n_fail++; $display("FAIL idle_timing: release %0d cycles after last launch, required %0d", first_fcyc - act_txcyc[1], IT + 2); end
  endtask

  task automatic test_reset_mid_line();
    bit seen;
    do_reset();
    load_line(1, 1, 1);
    run_traffic(0, 200);
    clear_src();
    src_mem[2][0] = 8'h58; src_len[2] = 1;
    drive_reqs();
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      if (tx_en) seen = 1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL midreset_launch: no launch within 20 cycles, required one"); end
    tx_busy = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd2) begin n_fail++; $display("FAIL midreset_pre: grant %b id %0d, required 1 id 2", grant_valid, grant_id); end
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, tx_en, tx_data, grant_valid, grant_id, line_forced} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h, required 0", {req_ready, tx_en, tx_data, grant_valid, grant_id, line_forced});
    end
    clear_src(); drive_reqs(); tx_busy = 1'b0; busy_cnt = 0;
    @(posedge clk); #1 resetn = 1'b1;
    model_rr = 0;
    load_line(0, 1, 1); load_line(3, 1, 1);
    run_traffic(1, 300);
    n_checks++; if (act_grant[0] !== 0 || grant_diff() !== -1) begin n_fail++; $display("FAIL midreset_rr: first grant %0d, required 0", act_grant[0]); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; busy_cnt = 0; model_rr = 0;
    resetn = 1'b0; req_valid = '0; req_data = '0; tx_busy = 1'b0;
    clear_src();
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_line_limit();
    test_lf_at_limit();
    test_idle_timeout();
    test_reset_mid_line();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
